multi_voice_pwm_mixer: RTL and testbench
========================================

Name: multi_voice_pwm_mixer

Overview:
Parametrised successor to the single-stream sound output path. Mixes NUM_VOICES unsigned voice samples with per-voice CPU-programmable volumes, using a time-multiplexed multiply-accumulate once per PWM frame. Scales the mix to a PWM threshold and drives the amplifier PWM and shutdown pins. Sits between the voice generators and the board audio amplifier, on the same CPU write bus as the sound RAM.

Parameters:
NUM_VOICES, 3, number of mixed voices (1..8)
SAMPLE_W, 8, unsigned sample width per voice
VOL_W, 4, volume register width per voice
PWM_PERIOD, 1042, clocks per PWM frame (100 MHz / 96 kHz); must be >= NUM_VOICES+3
CNT_W, 11, PWM counter width; must satisfy 2^CNT_W > PWM_PERIOD
BASE_ADDR, 16'h5050, CPU address of the voice 0 volume register

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  CPU write strobe
ram_addr  in  16  CPU write address
cpu_data  in  8  CPU write data
voice_sample  in  NUM_VOICES*SAMPLE_W  voice v sample at bits [v*SAMPLE_W +: SAMPLE_W]
sample_req  out  1  one-cycle pulse; producers present next samples by the following cycle
ampPWM  out  1  amplifier PWM output
ampSD  out  1  amplifier enable (high = on)

Behaviour:
- Reset (synchronous, active-high, any cycle including mid-MAC):
  - cnt=0, all volume regs=0, ctrl=0, thresh=0, mix_result=0, acc=0, FSM=IDLE.
  - ampPWM=0, ampSD=0, sample_req=0 on the cycle after rst is sampled high.
- Register map (write-only, a write occurs when wr_en=1 and ram_addr matches):
  - BASE_ADDR+v, v<NUM_VOICES: vol[v] <= cpu_data[VOL_W-1:0].
  - BASE_ADDR+NUM_VOICES: ctrl <= cpu_data[1:0]; bit0 = enable, bit1 = mute.
  - Any other address: ignored; no register changes.
- PWM counter:
  - cnt counts 0..PWM_PERIOD-1 and wraps to 0.
  - sample_req=1 exactly in the cycle where cnt==PWM_PERIOD-1.
- Frame boundary (the edge where cnt wraps to 0):
  - thresh <= mix_result.
  - snap_sample <= voice_sample; snap_vol <= vol regs (pre-write values if a write lands on the same edge).
  - FSM <= ACC; acc <= 0; idx <= 0.
- FSM states: IDLE, ACC, SCALE.
  - ACC: one voice per cycle, acc <= acc + snap_sample[idx]*snap_vol[idx]. Leaves for SCALE after idx==NUM_VOICES-1.
  - SCALE: mix_result <= (acc * PWM_PERIOD) >> SUM_W; then -> IDLE.
  - The FSM always finishes before the next frame boundary.
- Arithmetic:
  - SUM_W = SAMPLE_W + VOL_W + clog2(NUM_VOICES), minimum 1 extra bit.
  - acc is SUM_W bits; no overflow is possible by construction.
  - The scale product uses the full SUM_W+CNT_W width and truncates.
  - mix_result < PWM_PERIOD always.
- Latency: the sample captured at frame k appears in ampPWM during frame k+1.
- Output stage (registered):
  - ampPWM <= enable & ~mute & (cnt < thresh).
  - ampPWM is high for exactly thresh clocks per frame, delayed one clock from cnt.
  - thresh=0 gives constant low; no glitch pulse.
  - ampSD <= enable; mute does not affect ampSD.
- Simultaneous write and MAC: the MAC uses only snapshots; register writes never affect the frame in progress.

Test Plan:
- Reset hold then release, no writes -> ampSD=0, ampPWM=0 for 3 full frames; sample_req pulses every 1042 clocks at cnt=1041, 1 cycle wide.
- Write 0x01 to 0x5053, 0x0F to 0x5050; voice0=255, others 0 -> from the 2nd frame boundary after the writes, ampPWM high 243 of 1042 clocks each frame; ampSD=1.
- All volumes 0x0F, all samples 255 -> ampPWM high 729 clocks per frame (11475*1042>>14).
- ctrl=0x03 with a nonzero mix -> ampPWM=0 every cycle, ampSD=1. Then ctrl=0x01 -> PWM resumes at the next frame boundary with the unchanged width.
- Write vol0=0x08 on the exact boundary edge -> that frame still uses the old vol0=15 (243). The following frame uses 8: 2040*1042>>14=129 clocks high.
- Assert rst for 1 cycle mid-ACC; also write to 0x5054 (unmapped) -> all outputs 0 next cycle, volumes cleared, and the unmapped write has no effect.

Source files
------------

// File: rtl/multi_voice_pwm_mixer.sv
// Multi-voice sample mixer with per-voice volume and PWM amplifier output.
// One time-multiplexed MAC pass per PWM frame; result becomes next frame's duty.
module multi_voice_pwm_mixer #(
  parameter int          NUM_VOICES = 3,
  parameter int          SAMPLE_W   = 8,
  parameter int          VOL_W      = 4,
  parameter int          PWM_PERIOD = 1042,
  parameter int          CNT_W      = 11,
  parameter logic [15:0] BASE_ADDR  = 16'h5050
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [15:0]                    ram_addr,
  input  logic [7:0]                     cpu_data,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  output logic                           sample_req,
  output logic                           ampPWM,
  output logic                           ampSD
);

  localparam int LOG_V  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SUM_W  = SAMPLE_W + VOL_W + LOG_V;
  localparam int PROD_W = SUM_W + CNT_W;
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SCALE
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_thresh;
  logic [CNT_W-1:0]     r_mix;
  logic [SUM_W-1:0]     r_acc;
  logic [IDX_W-1:0]     r_idx;
  logic [1:0]           r_ctrl;
  logic [VOL_W-1:0]     r_vol    [NUM_VOICES];
  logic [VOL_W-1:0]     r_snap_v [NUM_VOICES];
  logic [SAMPLE_W-1:0]  r_snap_s [NUM_VOICES];
  logic                 r_req;
  logic                 r_pwm;
  logic                 r_sd;

  logic                 w_wrap;
  logic [15:0]          w_off;
  logic [SUM_W-1:0]     w_term;
  logic [PROD_W-1:0]    w_prod;

  assign w_wrap = (r_cnt == CNT_W'(PWM_PERIOD - 1));
  assign w_off  = ram_addr - BASE_ADDR;
  assign w_term = SUM_W'(r_snap_s[r_idx]) * SUM_W'(r_snap_v[r_idx]);
  // Full-width product so the >>SUM_W keeps mix_result below PWM_PERIOD
  assign w_prod = PROD_W'(r_acc) * PROD_W'(PWM_PERIOD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_thresh <= '0;
      r_mix    <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_ctrl   <= '0;
      r_req    <= 1'b0;
      r_pwm    <= 1'b0;
      r_sd     <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_vol[v]    <= '0;
        r_snap_v[v] <= '0;
        r_snap_s[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++)
        if (wr_en && w_off == 16'(v))
          r_vol[v] <= cpu_data[VOL_W-1:0];
      if (wr_en && w_off == 16'(NUM_VOICES))
        r_ctrl <= cpu_data[1:0];

      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      r_req <= (r_cnt == CNT_W'(PWM_PERIOD - 2));
      r_pwm <= r_ctrl[0] & ~r_ctrl[1] & (r_cnt < r_thresh);
      r_sd  <= r_ctrl[0];

      if (w_wrap) begin
        r_thresh <= r_mix;
        r_state  <= ACC;
        r_acc    <= '0;
        r_idx    <= '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
          r_snap_s[v] <= voice_sample[v*SAMPLE_W +: SAMPLE_W];
          r_snap_v[v] <= r_vol[v];
        end
      end else begin
        unique case (r_state)
          IDLE: r_state <= IDLE;
          ACC: begin
            r_acc <= r_acc + w_term;
            r_idx <= r_idx + 1'b1;
            if (r_idx == IDX_W'(NUM_VOICES - 1))
              r_state <= SCALE;
          end
          SCALE: begin
            r_mix   <= w_prod[SUM_W +: CNT_W];
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign sample_req = r_req;
  assign ampPWM     = r_pwm;
  assign ampSD      = r_sd;

endmodule

// File: tb/tb_multi_voice_pwm_mixer.sv
// Directed bench for multi_voice_pwm_mixer: duty per frame, mute,
// boundary-edge writes and mid-MAC reset.
module tb_multi_voice_pwm_mixer;

  localparam int P = 1042;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] ram_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic [23:0] voice_sample = '0;
  logic        sample_req;
  logic        ampPWM;
  logic        ampSD;

  int total = 0;
  int bad = 0;
  int f_pwm, f_sd, f_req, f_pos;

  multi_voice_pwm_mixer dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .ram_addr     (ram_addr),
    .cpu_data     (cpu_data),
    .voice_sample (voice_sample),
    .sample_req   (sample_req),
    .ampPWM       (ampPWM),
    .ampSD        (ampSD)
  );

  always #5 clk = ~clk;

  task automatic write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    ram_addr = a;
    cpu_data = d;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  task automatic sync();
    int k = 0;
    @(negedge clk);
    while (!sample_req && k < 2 * P) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!sample_req) begin
      bad++;
      $display("FAIL sync: no sample_req within %0d cycles", 2 * P);
    end
  endtask

  task automatic frame(input int n);
    f_pwm = 0;
    f_sd  = 0;
    f_req = 0;
    f_pos = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ampPWM) f_pwm++;
      if (ampSD) f_sd++;
      if (sample_req) begin
        f_req++;
        f_pos = i;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (ampPWM !== 1'b0) begin
      bad++;
      $display("FAIL rst_pwm: got %b want 0", ampPWM);
    end
    total++;
    if (ampSD !== 1'b0) begin
      bad++;
      $display("FAIL rst_sd: got %b want 0", ampSD);
    end
    total++;
    if (sample_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_req: got %b want 0", sample_req);
    end
    rst = 1'b0;
    sync();
    for (int f = 0; f < 3; f++) begin
      frame(P);
      total++;
      if (f_pwm != 0 || f_sd != 0) begin
        bad++;
        $display("FAIL idle_f%0d: pwm=%0d sd=%0d want 0 0", f, f_pwm, f_sd);
      end
      total++;
      if (f_req != 1 || f_pos != P - 1) begin
        bad++;
        $display("FAIL req_f%0d: count=%0d pos=%0d want 1 %0d",
                 f, f_req, f_pos, P - 1);
      end
    end
  endtask

  task automatic test_single();
    voice_sample = {8'd0, 8'd0, 8'd255};
    write(16'h5053, 8'h01);
    write(16'h5050, 8'h0F);
    sync();
    frame(P);
    total++;
    if (f_pwm != 0 || f_sd != P) begin
      bad++;
      $display("FAIL single_a: pwm=%0d sd=%0d want 0 %0d", f_pwm, f_sd, P);
    end
    for (int f = 0; f < 2; f++) begin
      frame(P);
      total++;
      if (f_pwm != 243 || f_sd != P) begin
        bad++;
        $display("FAIL single_f%0d: pwm=%0d sd=%0d want 243 %0d",
                 f, f_pwm, f_sd, P);
      end
    end
  endtask

  task automatic test_all();
    write(16'h5051, 8'h0F);
    write(16'h5052, 8'h0F);
    voice_sample = {8'd255, 8'd255, 8'd255};
    sync();
    frame(P);
    total++;
    if (f_pwm != 243) begin
      bad++;
      $display("FAIL all_a: pwm=%0d want 243", f_pwm);
    end
    frame(P);
    total++;
    if (f_pwm != 729) begin
      bad++;
      $display("FAIL all_b: pwm=%0d want 729", f_pwm);
    end
  endtask

  task automatic test_mute();
    write(16'h5053, 8'h03);
    sync();
    frame(P);
    total++;
    if (f_pwm != 0 || f_sd != P) begin
      bad++;
      $display("FAIL mute: pwm=%0d sd=%0d want 0 %0d", f_pwm, f_sd, P);
    end
    ram_addr = 16'h5053;
    cpu_data = 8'h01;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en    = 1'b0;
    frame(P - 1);
    total++;
    if (f_pwm != 729 || f_pos != P - 2) begin
      bad++;
      $display("FAIL unmute_a: pwm=%0d pos=%0d want 729 %0d",
               f_pwm, f_pos, P - 2);
    end
    frame(P);
    total++;
    if (f_pwm != 729) begin
      bad++;
      $display("FAIL unmute_b: pwm=%0d want 729", f_pwm);
    end
  endtask

  task automatic test_boundary_vol();
    voice_sample = {8'd0, 8'd0, 8'd255};
    frame(P);
    total++;
    if (f_pwm != 729) begin
      bad++;
      $display("FAIL bvol_x: pwm=%0d want 729", f_pwm);
    end
    ram_addr = 16'h5050;
    cpu_data = 8'h08;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en    = 1'b0;
    frame(P - 1);
    total++;
    if (f_pwm != 243) begin
      bad++;
      $display("FAIL bvol_y: pwm=%0d want 243", f_pwm);
    end
    frame(P);
    total++;
    if (f_pwm != 243) begin
      bad++;
      $display("FAIL bvol_z: pwm=%0d want 243", f_pwm);
    end
    frame(P);
    total++;
    if (f_pwm != 129) begin
      bad++;
      $display("FAIL bvol_w: pwm=%0d want 129", f_pwm);
    end
  endtask

  task automatic test_reset_mid();
    repeat (2) @(negedge clk);
    total++;
    if (ampPWM !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst_pwm: got %b want 1", ampPWM);
    end
    rst      = 1'b1;
    ram_addr = 16'h5054;
    cpu_data = 8'h03;
    wr_en    = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b0;
    total++;
    if ({ampPWM, ampSD, sample_req} !== 3'b000) begin
      bad++;
      $display("FAIL mid_rst: pwm/sd/req=%b want 000",
               {ampPWM, ampSD, sample_req});
    end
    write(16'h5053, 8'h01);
    write(16'h5050, 8'h0F);
    write(16'h5054, 8'h02);
    write(16'h504F, 8'h0F);
    voice_sample = {8'd255, 8'd255, 8'd255};
    sync();
    frame(P);
    total++;
    if (f_pwm != 0 || f_sd != P) begin
      bad++;
      $display("FAIL post_rst_a: pwm=%0d sd=%0d want 0 %0d", f_pwm, f_sd, P);
    end
    frame(P);
    total++;
    if (f_pwm != 243 || f_sd != P) begin
      bad++;
      $display("FAIL post_rst_b: pwm=%0d sd=%0d want 243 %0d",
               f_pwm, f_sd, P);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all();
    test_mute();
    test_boundary_vol();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
